// File: rtl/alu_entry_controller.sv
// Entry sequencer for the 16-bit ALU lab datapath: debounces Enter and walks
// operand A, operand B, opcode and result display, holding the ALU inputs.
module alu_entry_controller #(
  parameter int unsigned N_DEBOUNCER = 10
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        Enter,
  input  logic [15:0] DataIn,
  input  logic [15:0] AluResult,
  input  logic [3:0]  AluFlags,
  output logic [15:0] OpA,
  output logic [15:0] OpB,
  output logic [1:0]  OpCode,
  output logic [15:0] ToDisplay,
  output logic [3:0]  Flags,
  output logic [2:0]  Status
);

  localparam int unsigned CntW = $clog2(N_DEBOUNCER + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(N_DEBOUNCER - 1);

  // Encodings double as the step code shown on Status.
  typedef enum logic [2:0] {
    StWaitA  = 3'b001,
    StWaitB  = 3'b010,
    StWaitOp = 3'b100,
    StShow   = 3'b111
  } state_e;

  logic            sync_meta_q;
  logic            sync_q;
  logic            stable_q;
  logic            press_q;
  logic [CntW-1:0] cnt_q;
  logic            flip;
  state_e          state_q;

  // stable follows sync once they have disagreed for N_DEBOUNCER cycles in a row.
  assign flip = (sync_q != stable_q) && (cnt_q == CntLast);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
      stable_q    <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync_meta_q <= Enter;
      sync_q      <= sync_meta_q;
      press_q     <= flip & sync_q;
      if ((sync_q == stable_q) || flip) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (flip) begin
        stable_q <= sync_q;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= StWaitA;
      OpA     <= '0;
      OpB     <= '0;
      OpCode  <= '0;
      Flags   <= '0;
    end else begin
      unique case (state_q)
        StWaitA: begin
          if (press_q) begin
            OpA     <= DataIn;
            state_q <= StWaitB;
          end
        end
        StWaitB: begin
          if (press_q) begin
            OpB     <= DataIn;
            state_q <= StWaitOp;
          end
        end
        StWaitOp: begin
          if (press_q) begin
            OpCode  <= DataIn[1:0];
            state_q <= StShow;
          end
        end
        StShow: begin
          if (press_q) begin
            Flags   <= '0;
            state_q <= StWaitA;
          end else begin
            Flags <= AluFlags;
          end
        end
        default: begin
          Flags   <= '0;
          state_q <= StWaitA;
        end
      endcase
    end
  end

  assign Status    = state_q;
  assign ToDisplay = (state_q == StShow) ? AluResult : DataIn;

endmodule

// File: tb/tb_alu_entry_controller.sv
// Bench for alu_entry_controller: a sample-history model of the debounced
// entry sequence checked every cycle, plus literal expectations per scenario.
module tb_alu_entry_controller;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        Enter = 1'b0;
  logic [15:0] DataIn = 16'h0000;
  logic [15:0] AluResult;
  logic [3:0]  AluFlags;
  logic [15:0] OpA;
  logic [15:0] OpB;
  logic [1:0]  OpCode;
  logic [15:0] ToDisplay;
  logic [3:0]  Flags;
  logic [2:0]  Status;

  int checks = 0;
  int failures = 0;

  alu_entry_controller #(.N_DEBOUNCER(N)) dut (
    .clk(clk), .resetN(resetN), .Enter(Enter), .DataIn(DataIn),
    .AluResult(AluResult), .AluFlags(AluFlags),
    .OpA(OpA), .OpB(OpB), .OpCode(OpCode),
    .ToDisplay(ToDisplay), .Flags(Flags), .Status(Status)
  );

  always #5 clk = ~clk;

  // Lab ALU: 00 add, 01 subtract (C = borrow), 10 and, 11 or. Returns {N,Z,C,V,result}.
  function automatic logic [19:0] alu(input logic [15:0] a, input logic [15:0] b,
                                      input logic [1:0] op);
    logic [16:0] w;
    logic [15:0] r;
    logic c;
    logic v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      2'b00: begin
        w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      2'b01: begin
        w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = w[16];
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      2'b10: r = a & b;
      default: r = a | b;
    endcase
    return {r[15], (r == 16'h0000), c, v, r};
  endfunction

  assign {AluFlags, AluResult} = alu(OpA, OpB, OpCode);

  // Model state: step 0..3 = A, B, opcode, show.
  int          m_step;
  logic [15:0] m_opa;
  logic [15:0] m_opb;
  logic [1:0]  m_opc;
  logic [3:0]  m_flags;
  bit          m_s1, m_s2, m_stable, m_press;
  bit          hist[$];

  task automatic model_step();
    bit pr;
    bit differ;
    logic [19:0] a;
    pr = m_press;
    hist.push_back(m_s2);
    if (hist.size() > int'(N)) void'(hist.pop_front());
    if (pr) begin
      case (m_step)
        0: m_opa = DataIn;
        1: m_opb = DataIn;
        2: m_opc = DataIn[1:0];
        default: m_flags = 4'h0;
      endcase
      m_step = (m_step + 1) % 4;
    end else if (m_step == 3) begin
      a = alu(m_opa, m_opb, m_opc);
      m_flags = a[19:16];
    end
    // Debounced level flips after N consecutive synchronized samples disagree with it.
    differ = (hist.size() == int'(N));
    foreach (hist[i]) if (hist[i] == m_stable) differ = 1'b0;
    m_press = 1'b0;
    if (differ) begin
      m_stable = ~m_stable;
      m_press = m_stable;
    end
    m_s2 = m_s1;
    m_s1 = Enter;
  endtask

  task automatic model_reset();
    m_step = 0; m_opa = '0; m_opb = '0; m_opc = '0; m_flags = '0;
    m_s1 = 1'b0; m_s2 = 1'b0; m_stable = 1'b0; m_press = 1'b0;
    hist.delete();
  endtask

  always @(posedge clk or negedge resetN) begin
    if (!resetN) model_reset();
    else model_step();
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] step_code(input int s);
    case (s)
      0: return 3'b001;
      1: return 3'b010;
      2: return 3'b100;
      default: return 3'b111;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [19:0] a;
    a = alu(m_opa, m_opb, m_opc);
    check("model_status", {13'd0, Status}, {13'd0, step_code(m_step)});
    check("model_display", ToDisplay, (m_step == 3) ? a[15:0] : DataIn);
    check("model_opa", OpA, m_opa);
    check("model_opb", OpB, m_opb);
    check("model_opcode", {14'd0, OpCode}, {14'd0, m_opc});
    check("model_flags", {12'd0, Flags}, {12'd0, m_flags});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [15:0] d);
    DataIn = d;
    Enter = 1'b1;
    tick(N + 8);
    Enter = 1'b0;
    tick(N + 8);
  endtask

  int hi[10] = '{1, 3, 2, 1, 3, 2, 1, 2, 3, 1};
  int lo[10] = '{2, 1, 3, 2, 1, 3, 2, 3, 1, 2};

  initial begin
    model_reset();
    DataIn = 16'hABCD;
    tick(3);
    check("reset_status", {13'd0, Status}, 16'h0001);
    check("reset_display", ToDisplay, 16'hABCD);
    check("reset_opa", OpA, 16'h0000);
    check("reset_flags", {12'd0, Flags}, 16'h0000);
    resetN = 1'b1;
    tick(3);

    press(16'h0005);
    check("seq_status_b", {13'd0, Status}, 16'h0002);
    press(16'h0003);
    check("seq_status_op", {13'd0, Status}, 16'h0004);
    press(16'h0001);
    check("seq_status_show", {13'd0, Status}, 16'h0007);
    check("seq_opa", OpA, 16'h0005);
    check("seq_opb", OpB, 16'h0003);
    check("seq_opcode", {14'd0, OpCode}, 16'h0001);
    check("seq_display", ToDisplay, 16'h0002);
    check("seq_flags", {12'd0, Flags}, 16'h0000);

    press(16'h0000);
    press(16'h0003);
    press(16'h0003);
    press(16'h0001);
    check("zero_flags", {12'd0, Flags}, 16'h0004);
    press(16'h1234);
    check("wrap_status", {13'd0, Status}, 16'h0001);
    check("wrap_flags", {12'd0, Flags}, 16'h0000);
    check("wrap_opa", OpA, 16'h0003);
    check("wrap_opcode", {14'd0, OpCode}, 16'h0001);
    check("wrap_display", ToDisplay, 16'h1234);

    DataIn = 16'h00C3;
    Enter = 1'b1;
    tick(200);
    check("held_status", {13'd0, Status}, 16'h0002);
    check("held_opa", OpA, 16'h00C3);
    Enter = 1'b0;
    DataIn = 16'h5555;
    tick(2 * N + 6);
    check("held_after_status", {13'd0, Status}, 16'h0002);
    check("held_after_opa", OpA, 16'h00C3);

    DataIn = 16'h0042;
    for (int i = 0; i < 10; i++) begin
      Enter = 1'b1;
      tick(hi[i]);
      Enter = 1'b0;
      tick(lo[i]);
    end
    check("bounce_status", {13'd0, Status}, 16'h0002);
    Enter = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    check("bounce_early", {13'd0, Status}, 16'h0002);
    @(posedge clk);
    #1;
    check("bounce_advance", {13'd0, Status}, 16'h0004);
    tick(4);
    Enter = 1'b0;
    tick(2 * N + 6);
    check("bounce_once", {13'd0, Status}, 16'h0004);
    check("bounce_opb", OpB, 16'h0042);

    resetN = 1'b0;
    #1;
    check("midreset_status", {13'd0, Status}, 16'h0001);
    check("midreset_opa", OpA, 16'h0000);
    check("midreset_opb", OpB, 16'h0000);
    check("midreset_opcode", {14'd0, OpCode}, 16'h0000);
    check("midreset_display", ToDisplay, 16'h0042);
    tick(1);
    resetN = 1'b1;
    tick(2);

    press(16'h7FFF);
    press(16'h0001);
    press(16'h0000);
    check("ovf_status", {13'd0, Status}, 16'h0007);
    check("ovf_display", ToDisplay, 16'h8000);
    check("ovf_flags", {12'd0, Flags}, 16'h0009);
    press(16'h0000);
    check("ovf_wrap_status", {13'd0, Status}, 16'h0001);
    check("ovf_wrap_opa", OpA, 16'h7FFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
